// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder/subtractor.
//   RCA_DEFAULT_WIDTH : default operand/result width
//   OP_ADD / OP_SUB   : encodings of the add_sub_b operation select
package rca_pkg;

  localparam int   RCA_DEFAULT_WIDTH = 32;
  localparam logic OP_ADD            = 1'b0;
  localparam logic OP_SUB            = 1'b1;

endpackage : rca_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell, purely combinational.
// Ports:
//   a, b : operand bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// Parameterised two's-complement adder/subtractor built from an explicit
// chain of full_adder cells; the carry ripples from bit 0 up to the MSB.
// The combinational result is the primary output; a registered copy of the
// result and flags is provided for callers that need a timed output.
//
// Ports:
//   clk        : clock for the registered path (rising edge)
//   rst_n      : asynchronous active-low reset of the registered path only
//   add_sub_b  : 0 = in1 + in2, 1 = in1 - in2
//   in1, in2   : operands (raw bit vectors, BUS_WIDTH bits)
//   out        : combinational result, modulo 2^BUS_WIDTH
//   carry_out  : carry out of the MSB cell (for subtract: 1 = no borrow)
//   out_q      : out registered on each rising clk
//   carry_q    : carry_out registered on each rising clk
//   overflow   : signed overflow flag        (only with RCA_OVERFLOW_EN)
//   overflow_q : registered signed overflow  (only with RCA_OVERFLOW_EN)
//
// Optional feature macro: RCA_OVERFLOW_EN adds the overflow / overflow_q ports.
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int BUS_WIDTH = RCA_DEFAULT_WIDTH  // legal range 2..64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 add_sub_b,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 carry_out,
  output logic [BUS_WIDTH-1:0] out_q,
`ifdef RCA_OVERFLOW_EN
  output logic                 carry_q,
  output logic                 overflow,
  output logic                 overflow_q
`else
  output logic                 carry_q
`endif
);

  // carry[i] is the carry into cell i; carry[BUS_WIDTH] leaves the MSB.
  logic [BUS_WIDTH:0]   carry;
  logic [BUS_WIDTH-1:0] b_sel;
  logic [BUS_WIDTH-1:0] sum;

  // Subtract as in1 + ~in2 + 1: invert B and inject the +1 as carry-in.
  assign b_sel    = (add_sub_b == OP_SUB) ? ~in2 : in2;
  assign carry[0] = add_sub_b;

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a    (in1[i]),
      .b    (b_sel[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign out       = sum;
  assign carry_out = carry[BUS_WIDTH];

`ifdef RCA_OVERFLOW_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = carry[BUS_WIDTH] ^ carry[BUS_WIDTH-1];
`endif

  // ---- registered result stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      carry_q    <= 1'b0;
`ifdef RCA_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      out_q      <= out;
      carry_q    <= carry_out;
`ifdef RCA_OVERFLOW_EN
      overflow_q <= overflow;
`endif
    end
  end

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Directed self-checking bench for ripple_carry_adder (BUS_WIDTH = 32).
module tb_ripple_carry_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         add_sub_b;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] out;
  logic         carry_out;
  logic [W-1:0] out_q;
  logic         carry_q;
`ifdef RCA_OVERFLOW_EN
  logic         overflow;
  logic         overflow_q;
`endif

  int passed = 0;
  int total  = 0;

  ripple_carry_adder #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .add_sub_b  (add_sub_b),
    .in1        (in1),
    .in2        (in2),
    .out        (out),
    .carry_out  (carry_out),
    .out_q      (out_q),
`ifdef RCA_OVERFLOW_EN
    .carry_q    (carry_q),
    .overflow   (overflow),
    .overflow_q (overflow_q)
`else
    .carry_q    (carry_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic apply(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    add_sub_b = op;
    in1       = a;
    in2       = b;
  endtask

  initial begin
    rst_n = 1'b0;
    apply(1'b0, 32'd0, 32'd0);

    // Combinational path, checked 1 ns after each input change.
    #1 apply(1'b0, 32'd12, 32'd24);
    #1 check("add_12_24_out", 64'(out), 64'd36);
       check("add_12_24_cout", 64'(carry_out), 64'd0);
    apply(1'b1, 32'd110, 32'd24);
    #1 check("sub_110_24_out", 64'(out), 64'd86);
       check("sub_110_24_cout", 64'(carry_out), 64'd1);
    apply(1'b0, 32'hFFFF_FFFF, 32'd1);
    #1 check("add_wrap_out", 64'(out), 64'd0);
       check("add_wrap_cout", 64'(carry_out), 64'd1);
    apply(1'b1, 32'd0, 32'd1);
    #1 check("sub_borrow_out", 64'(out), 64'hFFFF_FFFF);
       check("sub_borrow_cout", 64'(carry_out), 64'd0);
    apply(1'b0, 32'h1234_5678, 32'h8765_4321);
    #1 check("add_pattern_out", 64'(out), 64'h9999_9999);
       check("add_pattern_cout", 64'(carry_out), 64'd0);
    apply(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    #1 check("sub_equal_out", 64'(out), 64'd0);
       check("sub_equal_cout", 64'(carry_out), 64'd1);
    apply(1'b1, 32'd5, 32'd7);
    #1 check("sub_neg_out", 64'(out), 64'hFFFF_FFFE);
       check("sub_neg_cout", 64'(carry_out), 64'd0);
    apply(1'b0, 32'hAAAA_AAAA, 32'h5555_5556);
    #1 check("add_fullripple_out", 64'(out), 64'd0);
       check("add_fullripple_cout", 64'(carry_out), 64'd1);

`ifdef RCA_OVERFLOW_EN
    apply(1'b0, 32'h7FFF_FFFF, 32'd1);
    #1 check("ovf_add_out", 64'(out), 64'h8000_0000);
       check("ovf_add_flag", 64'(overflow), 64'd1);
       check("ovf_add_cout", 64'(carry_out), 64'd0);
    apply(1'b1, 32'h8000_0000, 32'd1);
    #1 check("ovf_sub_out", 64'(out), 64'h7FFF_FFFF);
       check("ovf_sub_flag", 64'(overflow), 64'd1);
    apply(1'b0, 32'd12, 32'd24);
    #1 check("ovf_none_flag", 64'(overflow), 64'd0);
`endif

    // Registered path held in reset across a clock edge.
    apply(1'b0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_out_q", 64'(out_q), 64'd0);
    check("rst_hold_carry_q", 64'(carry_q), 64'd0);
`ifdef RCA_OVERFLOW_EN
    check("rst_hold_ovf_q", 64'(overflow_q), 64'd0);
`endif

    // Release reset, 12+24 captured on the first rising edge.
    rst_n = 1'b1;
    apply(1'b0, 32'd12, 32'd24);
    @(posedge clk);
    #1 check("reg_first_out_q", 64'(out_q), 64'd36);
       check("reg_first_carry_q", 64'(carry_q), 64'd0);

    // New inputs do not reach out_q until the next edge.
    apply(1'b1, 32'd110, 32'd24);
    #2 check("reg_hold_out_q", 64'(out_q), 64'd36);
    @(posedge clk);
    #1 check("reg_second_out_q", 64'(out_q), 64'd86);
       check("reg_second_carry_q", 64'(carry_q), 64'd1);

    // Carry capture on an add that overflows unsigned.
    apply(1'b0, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk);
    #1 check("reg_wrap_out_q", 64'(out_q), 64'd1);
       check("reg_wrap_carry_q", 64'(carry_q), 64'd1);
`ifdef RCA_OVERFLOW_EN
    apply(1'b0, 32'h7FFF_FFFF, 32'd1);
    @(posedge clk);
    #1 check("reg_ovf_q", 64'(overflow_q), 64'd1);
`endif

    // Mid-cycle asynchronous reset clears registers, combinational path live.
    apply(1'b1, 32'd110, 32'd24);
    @(posedge clk);
    #1 check("pre_async_out_q", 64'(out_q), 64'd86);
    #2 rst_n = 1'b0;
    #1 check("async_out_q", 64'(out_q), 64'd0);
       check("async_carry_q", 64'(carry_q), 64'd0);
`ifdef RCA_OVERFLOW_EN
       check("async_ovf_q", 64'(overflow_q), 64'd0);
`endif
       check("async_comb_out", 64'(out), 64'd86);
       check("async_comb_cout", 64'(carry_out), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_ripple_carry_adder
